// File: rtl/buffered_matrixn_pkg.sv
// ============================================================================
// Module  : buffered_matrixn_pkg
// Brief   : Shared constants and helpers for the NxN grayscale window converter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package buffered_matrixn_pkg;

    // Luma approximation: (1*R + 2*G + 1*B) >> 2
    localparam int unsigned GRAY_WEIGHT_R = 1;
    localparam int unsigned GRAY_WEIGHT_G = 2;
    localparam int unsigned GRAY_WEIGHT_B = 1;
    localparam int unsigned GRAY_SHIFT    = 2;

    function automatic int unsigned matrix_bits(input int unsigned n, input int unsigned d);
`ifdef MATRIX_CENTER_EN
        return n * n * d;
`else
        return (n * n - 1) * d;
`endif
    endfunction

    function automatic bit matrix_size_ok(input int unsigned n, input int unsigned cols,
                                          input int unsigned rows);
        return (n >= 3) && (n % 2 == 1) && (n <= cols) && (n <= rows);
    endfunction

    function automatic bit pixel_depth_ok(input int unsigned depth);
        return (depth >= 3) && (depth % 3 == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/buffered_matrixn_colorspace_converter_if.sv
// ============================================================================
// Module  : buffered_matrixn_colorspace_converter_if
// Brief   : Pixel-in / window-out bundle; master drives pixels, slave is the converter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface buffered_matrixn_colorspace_converter_if
    import buffered_matrixn_pkg::*;
#(
    parameter int P_FRAME_COLUMNS = 640,
    parameter int P_FRAME_ROWS    = 480,
    parameter int P_PIXEL_DEPTH   = 24,
    parameter int P_MATRIX_SIZE   = 3
);
    localparam int P_SUBPIXEL_DEPTH    = P_PIXEL_DEPTH / 3;
    localparam int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS);
    localparam int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS);
    localparam int P_PIXEL_MATRIX_BITS = int'(matrix_bits(P_MATRIX_SIZE, P_SUBPIXEL_DEPTH));

    logic                           I_PIXEL_VALID;
    logic                           I_FRAME_START;
    logic [P_PIXEL_DEPTH-1:0]       I_PIXEL;
    logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN;
    logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW;
    logic [P_PIXEL_MATRIX_BITS-1:0] O_PIXEL_MATRIX;
    logic                           O_PIXEL_MATRIX_READY;
    logic                           O_SYNC_ERROR;

    modport master (
        output I_PIXEL_VALID, I_FRAME_START, I_PIXEL,
        input  O_PIXEL_COLUMN, O_PIXEL_ROW, O_PIXEL_MATRIX, O_PIXEL_MATRIX_READY, O_SYNC_ERROR
    );

    modport slave (
        input  I_PIXEL_VALID, I_FRAME_START, I_PIXEL,
        output O_PIXEL_COLUMN, O_PIXEL_ROW, O_PIXEL_MATRIX, O_PIXEL_MATRIX_READY, O_SYNC_ERROR
    );

endinterface

`default_nettype wire

// File: rtl/buffered_matrixn_colorspace_converter_rgb_to_gray.sv
// ============================================================================
// Module  : rgb_to_gray
// Brief   : One-register RGB to grayscale stage; valid and frame start ride along.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rgb_to_gray
    import buffered_matrixn_pkg::*;
#(
    parameter int P_PIXEL_DEPTH = 24
)(
    input  wire logic                         clk_i,
    input  wire logic                         rst_i,
    input  wire logic                         valid_i,
    input  wire logic                         frame_start_i,
    input  wire logic [P_PIXEL_DEPTH-1:0]     pixel_i,
    output logic                              valid_o,
    output logic                              frame_start_o,
    output logic [P_PIXEL_DEPTH/3-1:0]        gray_o
);
    localparam int D     = P_PIXEL_DEPTH / 3;
    localparam int SUM_W = D + int'(GRAY_SHIFT);

    logic [D-1:0]     red, green, blue;
    logic [SUM_W-1:0] sum;
    logic [D-1:0]     gray_d, gray_q;
    logic             valid_q, fs_q;

    assign {red, green, blue} = pixel_i;

    // The weights sum to 1 << GRAY_SHIFT, so SUM_W bits can never overflow.
    assign sum = SUM_W'(GRAY_WEIGHT_R) * SUM_W'(red)
               + SUM_W'(GRAY_WEIGHT_G) * SUM_W'(green)
               + SUM_W'(GRAY_WEIGHT_B) * SUM_W'(blue);
    assign gray_d = D'(sum >> GRAY_SHIFT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            gray_q  <= '0;
        end else begin
            valid_q <= valid_i;
            fs_q    <= valid_i & frame_start_i;
            if (valid_i) begin
                gray_q <= gray_d;
            end
        end
    end

    assign valid_o       = valid_q;
    assign frame_start_o = fs_q;
    assign gray_o        = gray_q;

endmodule

`default_nettype wire

// File: rtl/buffered_matrixn_colorspace_converter.sv
// ============================================================================
// Module  : buffered_matrixn_colorspace_converter
// Brief   : RGB stream -> grayscale NxN window with N-1 line buffers.
//           Build option MATRIX_CENTER_EN keeps the center pixel in the window.
// Revision: 1.0
// ============================================================================
`default_nettype none

module buffered_matrixn_colorspace_converter
    import buffered_matrixn_pkg::*;
#(
    parameter int P_FRAME_COLUMNS = 640,
    parameter int P_FRAME_ROWS    = 480,
    parameter int P_PIXEL_DEPTH   = 24,
    parameter int P_MATRIX_SIZE   = 3
)(
    input wire logic I_CLK,
    input wire logic I_RESET,
    buffered_matrixn_colorspace_converter_if.slave bus
);
    localparam int P_SUBPIXEL_DEPTH    = P_PIXEL_DEPTH / 3;
    localparam int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS);
    localparam int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS);
    localparam int P_PIXEL_MATRIX_BITS = int'(matrix_bits(P_MATRIX_SIZE, P_SUBPIXEL_DEPTH));
    localparam int N         = P_MATRIX_SIZE;
    localparam int D         = P_SUBPIXEL_DEPTH;
    localparam int CB        = P_FRAME_COLUMN_BITS;
    localparam int RB        = P_FRAME_ROW_BITS;
    localparam int C_LINES   = N - 1;
    localparam int C_HALF    = (N - 1) / 2;
    localparam int C_CENTER  = C_HALF * N + C_HALF;
    localparam int C_ENTRIES = P_PIXEL_MATRIX_BITS / D;

    if (!matrix_size_ok(N, P_FRAME_COLUMNS, P_FRAME_ROWS) || !pixel_depth_ok(P_PIXEL_DEPTH))
    begin : g_bad_config
        $error("buffered_matrixn_colorspace_converter: unsupported size parameters");
    end

    // ---------------- stage 0: raster position of the accepted pixel -------------
    logic [CB-1:0] col_q, col_d, pos_col;
    logic [RB-1:0] row_q, row_d, pos_row;

    always_comb begin
        pos_col = bus.I_FRAME_START ? '0 : col_q;
        pos_row = bus.I_FRAME_START ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (bus.I_PIXEL_VALID) begin
            if (pos_col == CB'(P_FRAME_COLUMNS - 1)) begin
                col_d = '0;
                row_d = (pos_row == RB'(P_FRAME_ROWS - 1)) ? '0 : pos_row + RB'(1);
            end else begin
                col_d = pos_col + CB'(1);
                row_d = pos_row;
            end
        end
    end

    // ---------------- stage 1: grayscale plus its position -----------------------
    logic          gray_valid, gray_fs;
    logic [D-1:0]  gray;
    logic [CB-1:0] col1_q;
    logic [RB-1:0] row1_q;
    logic          origin1_q;

    rgb_to_gray #(
        .P_PIXEL_DEPTH (P_PIXEL_DEPTH)
    ) u_rgb_to_gray (
        .clk_i         (I_CLK),
        .rst_i         (I_RESET),
        .valid_i       (bus.I_PIXEL_VALID),
        .frame_start_i (bus.I_FRAME_START),
        .pixel_i       (bus.I_PIXEL),
        .valid_o       (gray_valid),
        .frame_start_o (gray_fs),
        .gray_o        (gray)
    );

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            col_q     <= '0;
            row_q     <= '0;
            col1_q    <= '0;
            row1_q    <= '0;
            origin1_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (bus.I_PIXEL_VALID) begin
                col1_q    <= pos_col;
                row1_q    <= pos_row;
                origin1_q <= (col_q == '0) && (row_q == '0);
            end
        end
    end

    // A frame start is only an error if the counters were not already at (0,0).
    assign bus.O_SYNC_ERROR = gray_fs & ~origin1_q;

    // ---------------- line buffers and window shift register ---------------------
    logic [D-1:0] line_mem [C_LINES][P_FRAME_COLUMNS];
    logic [D-1:0] col_tap  [N];
    logic [D-1:0] win_q    [N][N];
    logic [D-1:0] win_d    [N][N];

    always_comb begin
        for (int i = 0; i < C_LINES; i++) begin
            col_tap[i] = line_mem[i][col1_q];
        end
        col_tap[N-1] = gray;
        win_d = win_q;
        if (gray_valid) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
                win_d[i][N-1] = col_tap[i];
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (gray_valid) begin
            for (int i = 0; i < C_LINES - 1; i++) begin
                line_mem[i][col1_q] <= line_mem[i+1][col1_q];
            end
            line_mem[C_LINES-1][col1_q] <= gray;
        end
    end

    always_ff @(posedge I_CLK) begin
        win_q <= win_d;
    end

    // Row-major packing of the next window, top-left entry in the MSBs.
    wire [P_PIXEL_MATRIX_BITS-1:0] packed_d;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            localparam int K = gi * N + gj;
`ifdef MATRIX_CENTER_EN
            assign packed_d[(C_ENTRIES-1-K)*D +: D] = win_d[gi][gj];
`else
            if (K != C_CENTER) begin : g_keep
                localparam int KP = (K > C_CENTER) ? K - 1 : K;
                assign packed_d[(C_ENTRIES-1-KP)*D +: D] = win_d[gi][gj];
            end
`endif
        end
    end

    // ---------------- output registers ------------------------------------------
    logic                           complete;
    logic                           ready_q;
    logic [CB-1:0]                  out_col_q;
    logic [RB-1:0]                  out_row_q;
    logic [P_PIXEL_MATRIX_BITS-1:0] matrix_q;

    assign complete = gray_valid && (row1_q >= RB'(N - 1)) && (col1_q >= CB'(N - 1));

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            ready_q   <= 1'b0;
            out_col_q <= '0;
            out_row_q <= '0;
            matrix_q  <= '0;
        end else begin
            ready_q <= complete;
            if (complete) begin
                out_col_q <= col1_q - CB'(C_HALF);
                out_row_q <= row1_q - RB'(C_HALF);
                matrix_q  <= packed_d;
            end
        end
    end

    assign bus.O_PIXEL_MATRIX_READY = ready_q;
    assign bus.O_PIXEL_COLUMN       = out_col_q;
    assign bus.O_PIXEL_ROW          = out_row_q;
    assign bus.O_PIXEL_MATRIX       = matrix_q;

endmodule

`default_nettype wire
